// File: rtl/uart_linjuan03_rx_if.sv
// Serial-in / LED-out bundle for the 8N1 receiver.
// master = the line driver and LED observer, slave = the receiver.
interface uart_linjuan03_rx_if;
  logic       rx_uart;
  logic [7:0] led;

  modport master (output rx_uart, input led);
  modport slave  (input rx_uart, output led);
endinterface

// File: rtl/uart_linjuan03_rx.sv
// 8N1 UART receiver with a fixed bit period of T clocks.
// Each correctly framed byte is latched onto the LED bank until the next one.
module uart_linjuan03_rx #(
  parameter int T = 5208
) (
  input  logic               clk,
  input  logic               rst_n,  // active-high asynchronous reset despite the name
  uart_linjuan03_rx_if.slave bus
);

  localparam int CW = (T > 2) ? $clog2(T) : 2;
  localparam logic [CW-1:0] SAMPLE_PT = CW'(T / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(T - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic          sync1_reg, sync2_reg, prev_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    led_reg;

  logic fall;
  logic sample_pt;
  logic cnt_wrap;
  logic cnt_clear;
  logic idx_clear;
  logic idx_inc;
  logic shift_en;
  logic led_load;

  // Two-flop synchronizer plus a delayed copy for edge detection; all idle high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= bus.rx_uart;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign fall      = prev_reg & ~sync2_reg;
  assign sample_pt = (cnt_reg == SAMPLE_PT);
  assign cnt_wrap  = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (fall) state_next = START;
      START: begin
        if (sample_pt && sync2_reg) begin
          state_next = IDLE;
        end else if (cnt_wrap) begin
          state_next = DATA;
        end
      end
      DATA:  if (cnt_wrap && idx_reg == 3'd7) state_next = STOP;
      STOP:  if (sample_pt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Leaving STOP at the sample point (not the bit end) lets a back-to-back start bit be seen.
  always_comb begin
    cnt_clear = 1'b0;
    idx_clear = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    led_load  = 1'b0;
    case (state_reg)
      IDLE:  cnt_clear = 1'b1;
      START: begin
        cnt_clear = cnt_wrap;
        idx_clear = 1'b1;
      end
      DATA: begin
        cnt_clear = cnt_wrap;
        idx_inc   = cnt_wrap;
        shift_en  = sample_pt;
      end
      STOP: begin
        cnt_clear = cnt_wrap;
        led_load  = sample_pt && sync2_reg;
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      shift_reg <= 8'h00;
      led_reg   <= 8'h00;
    end else begin
      if (cnt_clear) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (idx_clear) begin
        idx_reg <= 3'd0;
      end else if (idx_inc) begin
        idx_reg <= idx_reg + 3'd1;
      end

      if (shift_en) begin
        shift_reg[idx_reg] <= sync2_reg;
      end

      if (led_load) begin
        led_reg <= shift_reg;
      end
    end
  end

  assign bus.led = led_reg;

endmodule

// File: tb/tb_uart_linjuan03_rx.sv
// Scoreboard bench for uart_linjuan03_rx at T=4: stimulus pushes expected LED
// values, a negedge monitor pops and compares whenever the LED bank changes.
`timescale 1ns/1ps
module tb_uart_linjuan03_rx;

  localparam int T = 4;

  logic clk;
  logic rst_n;

  uart_linjuan03_rx_if bus ();

  uart_linjuan03_rx #(.T(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         vec_count  = 0;
  int         miscompare = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_led   = 8'h00;
  logic       mon_en     = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompare++;
      $display("FAIL %s: led=%h expected=%h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: led=%h at %0t", name, act, $time);
    end
  endtask

  // Monitor: every LED change must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && bus.led !== prev_led) begin
      if (exp_q.size() == 0) begin
        vec_count++;
        miscompare++;
        $display("FAIL unexpected_led_change: led=%h expected no change from %h at %0t",
                 bus.led, prev_led, $time);
      end else begin
        check("led_update", bus.led, exp_q.pop_front());
      end
      prev_led = bus.led;
    end
  end

  task automatic idle(input int n);
    bus.rx_uart = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns T clocks into the stop bit with the line at the stop value.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx_uart = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_uart = b[i];
      repeat (T) @(negedge clk);
    end
    bus.rx_uart = stop;
    repeat (T) @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.rx_uart = 1'b1;

    // Reset held with the line idle: LEDs stay clear.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", bus.led, 8'h00);
    end
    rst_n  = 1'b0;
    mon_en = 1'b1;
    idle(4);
    check("after_reset", bus.led, 8'h00);

    // Framing error on a fresh receiver: nothing latched.
    send_byte(8'h31, 1'b0);
    idle(10);
    check("frame_err_hold", bus.led, 8'h00);

    // Single frame 1,0,0,0,1,1,0,0 -> 8'h31, updating 42 clocks after the start negedge.
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1);
    check("pre_stop_40", bus.led, 8'h00);
    @(negedge clk);
    check("pre_stop_41", bus.led, 8'h00);
    @(negedge clk);
    check("stop_sample", bus.led, 8'h31);
    idle(8);
    check("frame_held", bus.led, 8'h31);

    // One-clock start glitch, then a valid frame.
    bus.rx_uart = 1'b0;
    @(negedge clk);
    idle(12);
    check("glitch_ignored", bus.led, 8'h31);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(8);
    check("after_a5", bus.led, 8'hA5);

    // Back-to-back frames with a one-bit stop.
    exp_q.push_back(8'h31);
    exp_q.push_back(8'hC6);
    send_byte(8'h31, 1'b1);
    send_byte(8'hC6, 1'b1);
    idle(8);
    check("after_b2b", bus.led, 8'hC6);

    // Reset asserted halfway through data bit 4 of 8'hFF aborts the frame.
    exp_q.push_back(8'h00);
    bus.rx_uart = 1'b0;
    repeat (T) @(negedge clk);
    bus.rx_uart = 1'b1;
    repeat (4 * T + T / 2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_frame_reset", bus.led, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    idle(40);
    check("no_resume", bus.led, 8'h00);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle(8);
    check("after_5a", bus.led, 8'h5A);

    // Drain the scoreboard within a bounded window.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    vec_count++;
    if (exp_q.size() != 0) begin
      miscompare++;
      $display("FAIL scoreboard_drain: %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_linjuan03_rx.md
Name: uart_linjuan03_rx

Overview:
UART receiver, 8N1 format (1 start bit, 8 data bits LSB first, 1 stop bit, no parity), on a fixed baud period of T clocks.
- Each correctly framed byte is latched onto an 8-bit LED bank; the LEDs hold that byte until the next valid frame.
- Sits at the board's serial input pin. Drives LEDs directly.

Parameters:
T, default 5208, clocks per bit (9600 baud at 50 MHz). Legal range is T >= 4. Verification uses T=4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted, despite the name).
- rx_uart  input  1  asynchronous serial line; idles high.
- led  output  8  last valid received byte; bit0 = first data bit received.

Behaviour:
- Synchronizer:
  - rx_uart passes through a 2-flop synchronizer (both flops reset to 1), then a third registered copy for edge detection.
  - Falling edge = previous synced value 1 and current synced value 0.
- Reset: led=8'h00, state=IDLE, counters=0, shift register=0, synchronizer flops=1. Asserting reset mid-frame aborts the frame immediately.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synced falling edge go to START; cnt=0.
  - Bit counter cnt runs 0..T-1 and wraps to 0, advancing one bit period. The sample point is cnt == T/2 (integer division).
  - START: at the sample point, if the line is still 0, continue. If it reads 1, treat it as a glitch and return to IDLE. On wrap, go to DATA with bit index 0.
  - DATA: at each sample point shift the sampled bit into the byte at position idx (LSB first). On wrap, idx increments. After idx 7 wraps, go to STOP.
  - STOP: at the sample point:
    - if the line is 1, load led with the assembled byte on that same clock edge, then go to IDLE;
    - if it is 0 (framing error), discard the byte, leave led unchanged, go to IDLE.
  - STOP does not wait for the end of the stop bit, so a back-to-back next start bit is caught.
- In IDLE, a line held low with no falling edge (e.g. low straight out of reset) starts no frame.
- Latency: led updates at the clock edge of the stop-bit sample. That is the edge where cnt==T/2 in the 10th bit period counted from the detected edge, plus 3 clocks of synchronizer/edge-detect delay after the physical line edge.
- Falling edges during START, DATA or STOP are ignored (no re-sync).
- led is registered, glitch-free, and changes only on a valid stop bit or on reset.

Test Plan:
1. Reset check (T=4, clk 20 ns): assert rst_n high for 3 cycles with line idle high -> led=8'h00 throughout, no frame starts.
2. Single frame, LSB-first check:
   - Stimulus: idle 4 clocks, then start=0 (4 clk), then data 1,0,0,0,1,1,0,0 each 4 clk, then stop=1.
   - Expect led=8'h31 at the stop-bit sample and held afterwards.
   - led stays 8'h00 before that point.
3. Framing error: same frame as scenario 2 but stop bit 0 -> led unchanged (8'h00 after reset, or the previous byte).
4. Start glitch: line low for 1 clock, then high -> FSM returns to IDLE, led unchanged; a following valid 8'hA5 frame yields led=8'hA5.
5. Back-to-back frames: 8'h31 immediately followed by 8'hC6 with a 1-bit stop -> led=8'h31, then 8'hC6, with no lost frame.
6. Reset mid-frame: assert rst_n during data bit 4 of 8'hFF -> led=8'h00 at once, FSM in IDLE; the next valid 8'h5A frame yields led=8'h5A.
